// File: rtl/imem_arbiter.sv
// Two-port instruction memory arbiter: fetch (0) and prefetch (1)
// share one memory channel, one transaction in flight at a time.
module imem_arbiter #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              r0_valid_i,
  output logic              r0_ready_o,
  input  logic [ADDR_W-1:0] r0_addr_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [ADDR_W-1:0] rsp0_addr_o,
  output logic [LINE_W-1:0] rsp0_line_o,
  input  logic              r1_valid_i,
  output logic              r1_ready_o,
  input  logic [ADDR_W-1:0] r1_addr_i,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [ADDR_W-1:0] rsp1_addr_o,
  output logic [LINE_W-1:0] rsp1_line_o,
  input  logic              flush_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_pc_o,
  input  logic              mem_rsp_valid_i,
  output logic              mem_rsp_ready_o,
  input  logic [ADDR_W-1:0] mem_rsp_addr_i,
  input  logic [LINE_W-1:0] mem_line_i
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RSP,
    DROP
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   lock_q, lock_d;
  logic   lgnt_q, lgnt_d;
  logic   kill_q, kill_d;

  logic   c0, c1, gnt, req_v;
  logic   idle, wait_st, drop_st, kill0;
  logic   req_hs;

  // Grant select: a stalled grant is frozen, otherwise round-robin
  always_comb begin
    c0    = r0_valid_i & ~flush_i;
    c1    = r1_valid_i;
    gnt   = 1'b0;
    req_v = 1'b0;
    if (lock_q) begin
      gnt   = lgnt_q;
      req_v = lgnt_q ? r1_valid_i : r0_valid_i;
    end else begin
      gnt   = (c0 & c1) ? ~last_q : c1;
      req_v = c0 | c1;
    end
  end

  assign idle    = (state_q == IDLE) & rstn_i;
  assign wait_st = (state_q == WAIT_RSP) & rstn_i;
  assign drop_st = (state_q == DROP) & rstn_i;
  assign kill0   = wait_st & ~owner_q & flush_i;

  assign mem_req_valid_o = idle & req_v;
  assign mem_pc_o        = gnt ? r1_addr_i : r0_addr_i;
  assign r0_ready_o      = mem_req_valid_o & ~gnt & mem_req_ready_i;
  assign r1_ready_o      = mem_req_valid_o & gnt & mem_req_ready_i;
  assign req_hs          = mem_req_valid_o & mem_req_ready_i;

  assign rsp0_valid_o = wait_st & ~owner_q & ~flush_i & mem_rsp_valid_i;
  assign rsp1_valid_o = wait_st & owner_q & mem_rsp_valid_i;
  assign rsp0_addr_o  = mem_rsp_addr_i;
  assign rsp1_addr_o  = mem_rsp_addr_i;
  assign rsp0_line_o  = mem_line_i;
  assign rsp1_line_o  = mem_line_i;

  assign mem_rsp_ready_o = drop_st | kill0
    | (wait_st & (owner_q ? rsp1_ready_i : rsp0_ready_i));

  // Next-state: issue, wait for the line, or swallow a killed line
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    lock_d  = lock_q;
    lgnt_d  = lgnt_q;
    kill_d  = kill_q;
    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          state_d = (~gnt & (flush_i | kill_q)) ? DROP : WAIT_RSP;
          owner_d = gnt;
          last_d  = gnt;
          lock_d  = 1'b0;
          kill_d  = 1'b0;
        end else if (mem_req_valid_o) begin
          lock_d = 1'b1;
          lgnt_d = gnt;
          kill_d = kill_q | (flush_i & ~gnt);
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid_i & mem_rsp_ready_o) begin
          state_d = IDLE;
        end else if (kill0) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_rsp_valid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset lets port 0 win the first tie
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      lock_q  <= 1'b0;
      lgnt_q  <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      lgnt_q  <= lgnt_d;
      kill_q  <= kill_d;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed traffic, 5-cycle memory,
// per-cycle reference model plus literal service-order checks.
module tb_imem_arbiter;

  logic         clk = 1'b0;
  logic         rstn;
  logic         r0_valid, r0_ready_o;
  logic [31:0]  r0_addr;
  logic         rsp0_valid_o, rsp0_ready;
  logic [31:0]  rsp0_addr_o;
  logic [127:0] rsp0_line_o;
  logic         r1_valid, r1_ready_o;
  logic [31:0]  r1_addr;
  logic         rsp1_valid_o, rsp1_ready;
  logic [31:0]  rsp1_addr_o;
  logic [127:0] rsp1_line_o;
  logic         flush;
  logic         mem_req_valid_o, mem_rdy;
  logic [31:0]  mem_pc_o;
  logic         mv, mem_rsp_ready_o;
  logic [31:0]  pa;
  logic [127:0] mline;
  logic         mbusy;
  int           mcnt;

  always #5 clk = ~clk;

  imem_arbiter dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .r0_valid_i      (r0_valid),
    .r0_ready_o      (r0_ready_o),
    .r0_addr_i       (r0_addr),
    .rsp0_valid_o    (rsp0_valid_o),
    .rsp0_ready_i    (rsp0_ready),
    .rsp0_addr_o     (rsp0_addr_o),
    .rsp0_line_o     (rsp0_line_o),
    .r1_valid_i      (r1_valid),
    .r1_ready_o      (r1_ready_o),
    .r1_addr_i       (r1_addr),
    .rsp1_valid_o    (rsp1_valid_o),
    .rsp1_ready_i    (rsp1_ready),
    .rsp1_addr_o     (rsp1_addr_o),
    .rsp1_line_o     (rsp1_line_o),
    .flush_i         (flush),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_rdy),
    .mem_pc_o        (mem_pc_o),
    .mem_rsp_valid_i (mv),
    .mem_rsp_ready_o (mem_rsp_ready_o),
    .mem_rsp_addr_i  (pa),
    .mem_line_i      (mline)
  );

  assign mline = {4{pa ^ 32'h5A5A_0000}};

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int req_t  = 0;
  int lat    = -1;
  bit vseen  = 1'b1;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] served[$];
  logic [31:0] got0[$];
  logic [31:0] got1[$];

  int m_out   = -1;
  bit m_dead  = 1'b0;
  int m_last  = 1;
  int m_lock  = -1;
  bit m_lkill = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory: accepts one request, answers 5 cycles later, holds till taken
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mbusy <= 1'b0;
      mv    <= 1'b0;
      mcnt  <= 0;
      pa    <= '0;
    end else if (mem_req_valid_o && mem_rdy) begin
      mbusy <= 1'b1;
      mcnt  <= 5;
      pa    <= mem_pc_o;
    end else if (mbusy && !mv) begin
      if (mcnt == 1) mv <= 1'b1;
      else mcnt <= mcnt - 1;
    end else if (mv && mem_rsp_ready_o) begin
      mv    <= 1'b0;
      mbusy <= 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters: present queue head, hold it until accepted
  initial begin
    bit hs;
    r0_valid = 1'b0;
    r0_addr  = '0;
    forever begin
      @(negedge clk);
      hs = r0_valid && r0_ready_o;
      @(posedge clk);
      #1;
      if (hs) void'(q0.pop_front());
      r0_valid = q0.size() > 0;
      r0_addr  = (q0.size() > 0) ? q0[0] : '0;
    end
  end

  initial begin
    bit hs;
    r1_valid = 1'b0;
    r1_addr  = '0;
    forever begin
      @(negedge clk);
      hs = r1_valid && r1_ready_o;
      @(posedge clk);
      #1;
      if (hs) void'(q1.pop_front());
      r1_valid = q1.size() > 0;
      r1_addr  = (q1.size() > 0) ? q1[0] : '0;
    end
  end

  // Reference model: outstanding transaction as (port, dead) record
  task automatic model_step();
    int   g;
    logic v, c0, c1, kill, e_mrr;
    g = 0;
    v = 1'b0;
    if (!rstn) begin
      m_out   = -1;
      m_dead  = 1'b0;
      m_last  = 1;
      m_lock  = -1;
      m_lkill = 1'b0;
      chk("rst_req_valid", mem_req_valid_o, 0);
      chk("rst_r0_ready", r0_ready_o, 0);
      chk("rst_r1_ready", r1_ready_o, 0);
      chk("rst_rsp0_valid", rsp0_valid_o, 0);
      chk("rst_rsp1_valid", rsp1_valid_o, 0);
      chk("rst_rsp_ready", mem_rsp_ready_o, 0);
    end else if (m_out < 0) begin
      if (m_lock >= 0) begin
        g = m_lock;
        v = 1'b1;
      end else begin
        c0 = r0_valid && !flush;
        c1 = r1_valid;
        v  = c0 || c1;
        g  = (c0 && c1) ? 1 - m_last : (c1 ? 1 : 0);
      end
      chk("req_valid", mem_req_valid_o, v);
      if (v) chk("mem_pc", mem_pc_o, g ? r1_addr : r0_addr);
      chk("r0_ready", r0_ready_o, v && g == 0 && mem_rdy);
      chk("r1_ready", r1_ready_o, v && g == 1 && mem_rdy);
      chk("idle_rsp0_valid", rsp0_valid_o, 0);
      chk("idle_rsp1_valid", rsp1_valid_o, 0);
      chk("idle_rsp_ready", mem_rsp_ready_o, 0);
      if (v && mem_rdy) begin
        m_out   = g;
        m_last  = g;
        m_dead  = (g == 0) && (flush || m_lkill);
        m_lock  = -1;
        m_lkill = 1'b0;
      end else if (v) begin
        m_lock = g;
        if (g == 0 && flush) m_lkill = 1'b1;
      end
    end else begin
      kill  = m_dead || (m_out == 0 && flush);
      e_mrr = kill ? 1'b1 : (m_out == 1 ? rsp1_ready : rsp0_ready);
      chk("rsp0_valid", rsp0_valid_o, m_out == 0 && !kill && mv);
      chk("rsp1_valid", rsp1_valid_o, m_out == 1 && mv);
      chk("rsp_ready", mem_rsp_ready_o, e_mrr);
      chk("busy_req_valid", mem_req_valid_o, 0);
      chk("busy_r0_ready", r0_ready_o, 0);
      chk("busy_r1_ready", r1_ready_o, 0);
      if (rsp0_valid_o) begin
        chk("rsp0_addr", rsp0_addr_o, pa);
        chk("rsp0_line", rsp0_line_o, mline);
      end
      if (rsp1_valid_o) begin
        chk("rsp1_addr", rsp1_addr_o, pa);
        chk("rsp1_line", rsp1_line_o, mline);
      end
      if (mv && e_mrr) begin
        m_out  = -1;
        m_dead = 1'b0;
      end else if (kill) begin
        m_dead = 1'b1;
      end
    end
  endtask

  // Per-cycle compare and transaction log
  always @(negedge clk) begin
    model_step();
    if (mem_req_valid_o && mem_rdy) begin
      served.push_back(mem_pc_o);
      req_t = cyc + 1;
      vseen = 1'b0;
    end
    if ((rsp0_valid_o || rsp1_valid_o) && !vseen) begin
      vseen = 1'b1;
      lat   = cyc - req_t;
    end
    if (rsp0_valid_o && rsp0_ready) got0.push_back(rsp0_addr_o);
    if (rsp1_valid_o && rsp1_ready) got1.push_back(rsp1_addr_o);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int qsize(input int sel);
    if (sel == 0) return served.size();
    if (sel == 1) return got0.size();
    return got1.size();
  endfunction

  task automatic wait_q(input int sel, input int n);
    int k;
    k = 0;
    while (qsize(sel) < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wait_q_timeout", qsize(sel) >= n, 1);
  endtask

  task automatic wait_mv();
    int k;
    k = 0;
    while (!mv && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wait_mv_timeout", mv, 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (mbusy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle_timeout", mbusy, 0);
  endtask

  initial begin
    int ns;
    rstn       = 1'b0;
    flush      = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    mem_rdy    = 1'b1;
    #3;
    chk("lit_rst_req_valid", mem_req_valid_o, 0);
    chk("lit_rst_rsp_ready", mem_rsp_ready_o, 0);
    step(2);
    rstn = 1'b1;
    step(1);

    // Both ports contend: strict alternation starting with port 0
    q0.push_back(32'h200);
    q0.push_back(32'h200);
    q1.push_back(32'h300);
    wait_q(1, 2);
    wait_q(2, 1);
    chk("order0", served[0], 32'h200);
    chk("order1", served[1], 32'h300);
    chk("order2", served[2], 32'h200);
    chk("got1_300", got1[0], 32'h300);
    step(1);

    // Single fetch, 5-cycle response latency
    q0.push_back(32'h100);
    wait_q(1, 3);
    chk("got0_100", got0[2], 32'h100);
    chk("lat_100", lat, 5);
    step(1);

    // Flush in idle masks the pending fetch
    ns = served.size();
    flush = 1'b1;
    q0.push_back(32'h440);
    step(3);
    chk("flush_mask", served.size(), ns);
    flush = 1'b0;
    wait_q(1, 4);
    chk("got0_440", got0[3], 32'h440);
    step(1);

    // Flush while waiting: response dropped, prefetch follows
    ns = served.size();
    q0.push_back(32'h400);
    wait_q(0, ns + 1);
    step(2);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    q1.push_back(32'h500);
    wait_q(2, 2);
    chk("drop_400", got0.size(), 4);
    chk("got1_500", got1[1], 32'h500);
    chk("srv_400", served[ns], 32'h400);
    chk("srv_500", served[ns + 1], 32'h500);
    step(1);

    // Flush in the same cycle as the response
    rsp0_ready = 1'b0;
    q0.push_back(32'h480);
    wait_mv();
    step(1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    rsp0_ready = 1'b1;
    step(1);
    chk("drop_480", got0.size(), 4);
    wait_idle();
    step(1);

    // Prefetch consumer stalls 3 cycles; no new issue meanwhile
    ns = served.size();
    rsp1_ready = 1'b0;
    q1.push_back(32'h600);
    wait_mv();
    chk("stall_rsp_ready", mem_rsp_ready_o, 0);
    chk("stall_rsp1_valid", rsp1_valid_o, 1);
    q1.push_back(32'h700);
    step(3);
    chk("stall_no_issue", served.size(), ns + 1);
    rsp1_ready = 1'b1;
    wait_q(2, 4);
    chk("got1_600", got1[2], 32'h600);
    chk("got1_700", got1[3], 32'h700);
    step(1);

    // Stalled grant stays with port 1 when port 0 arrives
    ns = served.size();
    mem_rdy = 1'b0;
    q1.push_back(32'h800);
    step(2);
    q0.push_back(32'h900);
    step(3);
    @(negedge clk);
    chk("lock_pc", mem_pc_o, 32'h800);
    step(1);
    mem_rdy = 1'b1;
    wait_q(1, 5);
    chk("lock_srv0", served[ns], 32'h800);
    chk("lock_srv1", served[ns + 1], 32'h900);
    step(1);

    // Flush during a stalled port 0 grant: issued, then dropped
    ns = served.size();
    mem_rdy = 1'b0;
    q0.push_back(32'hA00);
    step(2);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(1);
    mem_rdy = 1'b1;
    wait_q(0, ns + 1);
    chk("lkill_srv", served[ns], 32'hA00);
    step(1);
    wait_idle();
    chk("lkill_drop", got0.size(), 5);
    step(1);

    // Reset mid-transaction, then a normal fetch
    ns = served.size();
    q0.push_back(32'hB00);
    wait_q(0, ns + 1);
    step(2);
    rstn = 1'b0;
    #1;
    chk("mid_rst_rsp0", rsp0_valid_o, 0);
    chk("mid_rst_ready", mem_rsp_ready_o, 0);
    step(2);
    rstn = 1'b1;
    q0.push_back(32'hC00);
    wait_q(1, 6);
    chk("got0_C00", got0[5], 32'hC00);
    step(2);
    chk("no_B00", got0.size(), 6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
